// File: rtl/hyperbus_delay_calib.sv
// HyperBus RWDS delay-line calibration: sweeps all 16 taps, runs test reads at each,
// and parks delay_o at the centre of the longest contiguous passing window.
module hyperbus_delay_calib #(
  parameter int          SettleCycles  = 4,
  parameter int          SamplesPerTap = 8,
  parameter logic [3:0]  DefaultDelay  = 4'd8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       trial_valid_o,
  input  logic       trial_ready_i,
  input  logic       result_valid_i,
  input  logic       result_pass_i,
  output logic [3:0] delay_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [3:0] win_start_o,
  output logic [4:0] win_len_o
);

  typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, EVAL, FINISH} state_t;

  state_t     state_q, state_d;
  logic [7:0] settle_q, samp_q;
  logic [3:0] tap_q, prev_delay_q;
  logic       pass_q;
  logic [4:0] run_len_q, best_len_q, run_len_d, half;
  logic [3:0] run_start_q, best_start_q, run_start_d, centre;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SETTLE;
      SETTLE:  if (settle_q == 8'(SettleCycles - 1)) state_d = REQ;
      REQ:     if (trial_ready_i) state_d = WAIT;
      WAIT:    if (result_valid_i)
                 state_d = (samp_q == 8'(SamplesPerTap - 1)) ? EVAL : REQ;
      EVAL:    state_d = (tap_q == 4'd15) ? FINISH : SETTLE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run tracker for the tap being evaluated; a new run starts at the first passing tap.
  always_comb begin
    run_len_d   = pass_q ? run_len_q + 5'd1 : 5'd0;
    run_start_d = (pass_q && run_len_q == 5'd0) ? tap_q : run_start_q;
    half        = (best_len_q - 5'd1) >> 1;
    centre      = best_start_q + half[3:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      samp_q        <= '0;
      tap_q         <= '0;
      prev_delay_q  <= '0;
      pass_q        <= 1'b1;
      run_len_q     <= '0;
      run_start_q   <= '0;
      best_len_q    <= '0;
      best_start_q  <= '0;
      trial_valid_o <= 1'b0;
      delay_o       <= DefaultDelay;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      win_start_o   <= '0;
      win_len_o     <= '0;
    end else begin
      state_q       <= state_d;
      trial_valid_o <= (state_d == REQ);
      busy_o        <= (state_d != IDLE);
      done_o        <= (state_q == FINISH);
      case (state_q)
        IDLE: if (start_i) begin
          prev_delay_q <= delay_o;
          tap_q        <= '0;
          delay_o      <= '0;
          samp_q       <= '0;
          settle_q     <= '0;
          pass_q       <= 1'b1;
          run_len_q    <= '0;
          run_start_q  <= '0;
          best_len_q   <= '0;
          best_start_q <= '0;
          error_o      <= 1'b0;
        end
        SETTLE: settle_q <= settle_q + 8'd1;
        WAIT: if (result_valid_i) begin
          pass_q <= pass_q & result_pass_i;
          samp_q <= samp_q + 8'd1;
        end
        EVAL: begin
          run_len_q   <= run_len_d;
          run_start_q <= run_start_d;
          // Strictly greater keeps the earlier window on a tie.
          if (run_len_d > best_len_q) begin
            best_len_q   <= run_len_d;
            best_start_q <= run_start_d;
          end
          if (tap_q != 4'd15) begin
            tap_q    <= tap_q + 4'd1;
            delay_o  <= tap_q + 4'd1;
            samp_q   <= '0;
            settle_q <= '0;
            pass_q   <= 1'b1;
          end
        end
        FINISH: begin
          win_start_o <= best_start_q;
          win_len_o   <= best_len_q;
          if (best_len_q != 5'd0) begin
            delay_o <= centre;
          end else begin
            delay_o <= prev_delay_q;
            error_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
